// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init_if.sv
// Access bus for the banked bit-mask memory: command/data in, ready and read data out.
// Subbank i occupies bits [i*sub_w +: sub_w] of every data/mask vector.
interface bsg_mem_1rw_sync_mask_write_bit_banked_init_if #(
  parameter int width_p          = 32,
  parameter int els_p            = 16,
  parameter int num_width_bank_p = 1
);
  localparam int addr_w = (els_p > 1) ? $clog2(els_p) : 1;

  logic [num_width_bank_p-1:0] v_i;
  logic                        w_i;
  logic [addr_w-1:0]           addr_i;
  logic [width_p-1:0]          w_mask_i;
  logic [width_p-1:0]          data_i;
  logic                        ready_o;
  logic [num_width_bank_p-1:0] data_v_o;
  logic [width_p-1:0]          data_o;

  // Handshake: an access is taken at a clk_i edge when ready_o=1 and |v_i=1;
  // read data for subbank i is presented the following cycle with data_v_o[i]=1.
  modport master (output v_i, w_i, addr_i, w_mask_i, data_i,
                  input  ready_o, data_v_o, data_o);
  modport slave  (input  v_i, w_i, addr_i, w_mask_i, data_i,
                  output ready_o, data_v_o, data_o);
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init.sv
// Single-port bit-masked memory split into column subbanks and row banks, zero-filled
// by an init FSM after reset, with optional per-subbank hold of the last read value.
module bsg_mem_1rw_sync_mask_write_bit_banked_init #(
  parameter int width_p           = 32,
  parameter int els_p             = 16,
  parameter int num_width_bank_p  = 1,
  parameter int num_depth_bank_p  = 1,
  parameter int latch_last_read_p = 1,
  parameter int init_on_reset_p   = 1,
  parameter int harden_p          = 0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_mem_1rw_sync_mask_write_bit_banked_init_if.slave bus
);
  localparam int sub_w      = width_p / num_width_bank_p;
  localparam int bank_depth = els_p / num_depth_bank_p;
  localparam int addr_w     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int row_w      = (bank_depth > 1) ? $clog2(bank_depth) : 1;
  localparam int bank_w     = (num_depth_bank_p > 1) ? $clog2(num_depth_bank_p) : 1;

  if (width_p <= 0 || (width_p & (width_p - 1)) != 0) begin : g_err_width
    $error("width_p must be a power of 2");
  end
  if (els_p <= 0 || (els_p & (els_p - 1)) != 0) begin : g_err_els
    $error("els_p must be a power of 2");
  end
  if (num_width_bank_p <= 0 || num_depth_bank_p <= 0) begin : g_err_zero
    $error("bank counts must be non-zero");
  end else if ((width_p % num_width_bank_p) != 0 || (els_p % num_depth_bank_p) != 0) begin : g_err_div
    $error("subbank width and bank depth must be integers");
  end
  if ((num_depth_bank_p & (num_depth_bank_p - 1)) != 0) begin : g_err_nd
    $error("num_depth_bank_p must be a power of 2");
  end
  // harden_p picks a hard macro in a foundry flow; this is the behavioral array.
  if (harden_p < 0) begin : g_err_harden
    $error("harden_p must be non-negative");
  end

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_e;
  localparam state_e rst_state = (init_on_reset_p != 0) ? INIT : READY;

  state_e            state_q, state_n;
  logic [row_w-1:0]  init_cnt_q, init_cnt_n;
  logic              init_we;
  logic              ready, acc;
  logic [row_w-1:0]  row;
  logic [bank_w-1:0] bank;
  logic [width_p-1:0] v_bits, w_bits;

  logic [width_p-1:0] mem     [num_depth_bank_p][bank_depth];
  logic [width_p-1:0] rdata_q [num_depth_bank_p];
  logic [num_width_bank_p-1:0] data_v_q;
  logic [bank_w-1:0]  rd_bank_q;
  logic [width_p-1:0] rd_mux, dout;

  if (bank_depth > 1) begin : g_row
    assign row = bus.addr_i[row_w-1:0];
  end else begin : g_row_one
    assign row = '0;
  end
  if (num_depth_bank_p > 1) begin : g_bank
    assign bank = bus.addr_i[addr_w-1 -: bank_w];
  end else begin : g_bank_one
    assign bank = '0;
  end

  always_comb begin
    v_bits = '0;
    for (int i = 0; i < num_width_bank_p; i++) v_bits[i*sub_w +: sub_w] = {sub_w{bus.v_i[i]}};
  end
  assign w_bits = v_bits & bus.w_mask_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= rst_state;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      init_cnt_q <= init_cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    init_cnt_n = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      INIT: begin
        init_we    = reset_n_i;
        init_cnt_n = init_cnt_q + row_w'(1);
        if (init_cnt_q == row_w'(bank_depth - 1)) state_n = READY;
      end
      default: ;
    endcase
  end

  assign ready       = (state_q == READY);
  assign acc         = ready && (|bus.v_i) && reset_n_i;
  assign bus.ready_o = ready;

  // Init writes the same row of every bank; otherwise only the addressed bank is enabled.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < num_depth_bank_p; b++) begin
      if (init_we) begin
        mem[b][init_cnt_q] <= '0;
      end else if (acc && bank == bank_w'(b)) begin
        if (bus.w_i) mem[b][row] <= (mem[b][row] & ~w_bits) | (bus.data_i & w_bits);
        else         rdata_q[b]  <= (rdata_q[b] & ~v_bits) | (mem[b][row] & v_bits);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      data_v_q  <= '0;
      rd_bank_q <= '0;
    end else begin
      data_v_q <= (acc && !bus.w_i) ? bus.v_i : '0;
      if (acc && !bus.w_i) rd_bank_q <= bank;
    end
  end

  assign rd_mux       = rdata_q[rd_bank_q];
  assign bus.data_v_o = data_v_q;
  assign bus.data_o   = dout;

  if (latch_last_read_p != 0) begin : g_latch
    logic [width_p-1:0] hold_q, dv_bits;
    always_comb begin
      dv_bits = '0;
      for (int i = 0; i < num_width_bank_p; i++) dv_bits[i*sub_w +: sub_w] = {sub_w{data_v_q[i]}};
    end
    assign dout = (rd_mux & dv_bits) | (hold_q & ~dv_bits);
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) hold_q <= '0;
      else            hold_q <= dout;
    end
  end else begin : g_no_latch
    assign dout = rd_mux;
  end
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_banked_init.sv
// Bench for the banked init memory: scoreboarded reads against a reference array,
// init timing, mid-init reset, last-read hold, and a no-init instance.
module tb_bsg_mem_1rw_sync_mask_write_bit_banked_init;
  localparam int W = 32, ELS = 16, NW = 2, ND = 2, SW = W / NW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_banked_init_if #(.width_p(W), .els_p(ELS), .num_width_bank_p(NW)) bus ();
  bsg_mem_1rw_sync_mask_write_bit_banked_init_if #(.width_p(W), .els_p(ELS), .num_width_bank_p(NW)) bus2 ();

  bsg_mem_1rw_sync_mask_write_bit_banked_init #(
    .width_p(W), .els_p(ELS), .num_width_bank_p(NW), .num_depth_bank_p(ND),
    .latch_last_read_p(1), .init_on_reset_p(1), .harden_p(0)
  ) dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));

  bsg_mem_1rw_sync_mask_write_bit_banked_init #(
    .width_p(W), .els_p(ELS), .num_width_bank_p(NW), .num_depth_bank_p(ND),
    .latch_last_read_p(1), .init_on_reset_p(0), .harden_p(0)
  ) dut_ni (.clk_i(clk), .reset_n_i(reset_n), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [NW-1:0] exp_v_q[$];
  int            exp_cyc_q[$];
  logic [W-1:0]  model_mem[ELS];
  logic [W-1:0]  model_hold;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ELS; i++) model_mem[i] = '0;
    model_hold = '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a read due this cycle must appear, and nothing may appear otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_cyc_q[0] == cyc) begin
        check("rd_v", W'(bus.data_v_o), W'(exp_v_q[0]));
        check("rd_data", bus.data_o, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_v_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        check("idle_v", W'(bus.data_v_o), '0);
      end
    end
  end

  // One-cycle access on the main DUT, called at a negedge while ready_o is high.
  task automatic access(input logic [NW-1:0] v, input logic w, input logic [3:0] a,
                        input logic [W-1:0] m, input logic [W-1:0] d);
    logic [W-1:0] vb, e;
    vb = '0;
    for (int i = 0; i < NW; i++) vb[i*SW +: SW] = {SW{v[i]}};
    bus.v_i = v; bus.w_i = w; bus.addr_i = a; bus.w_mask_i = m; bus.data_i = d;
    if (w) begin
      model_mem[a] = (model_mem[a] & ~(vb & m)) | (d & vb & m);
    end else if (v != '0) begin
      e = (model_mem[a] & vb) | (model_hold & ~vb);
      model_hold = e;
      exp_q.push_back(e);
      exp_v_q.push_back(v);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.v_i = '0;
  endtask

  task automatic idle(input int n);
    bus.v_i = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (bus.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, W'(n), W'(exp_n));
  endtask

  initial begin
    #200000;
    $display("watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.v_i = '0;  bus.w_i = 1'b0;  bus.addr_i = '0;  bus.w_mask_i = '0;  bus.data_i = '0;
    bus2.v_i = '0; bus2.w_i = 1'b0; bus2.addr_i = '0; bus2.w_mask_i = '0; bus2.data_i = '0;
    model_clear();

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", W'(bus.ready_o), '0);
    check("rst_v", W'(bus.data_v_o), '0);
    check("rst_data", bus.data_o, '0);
    check("ni_rst_ready", W'(bus2.ready_o), W'(1));
    check("ni_rst_v", W'(bus2.data_v_o), '0);
    check("ni_rst_data", bus2.data_o, '0);
    mon_en = 1'b1;

    // Reads held during init must be ignored.
    bus.v_i = 2'b11; bus.w_i = 1'b0; bus.addr_i = 4'd7;
    reset_n = 1'b1;
    wait_ready("init_cycles", 8);
    bus.v_i = '0;
    check("init_data", bus.data_o, '0);

    // Zero-filled corners, back to back across both row banks.
    access(2'b11, 1'b0, 4'd0, '0, '0);
    access(2'b11, 1'b0, 4'd7, '0, '0);
    access(2'b11, 1'b0, 4'd8, '0, '0);
    access(2'b11, 1'b0, 4'd15, '0, '0);
    idle(2);

    // Masked per-subbank writes.
    access(2'b01, 1'b1, 4'd5, 32'h0000_00F0, 32'hFFFF_FFFF);
    access(2'b11, 1'b0, 4'd5, '0, '0);
    access(2'b10, 1'b1, 4'd5, 32'hFFFF_0000, 32'hA5A5_0000);
    access(2'b11, 1'b0, 4'd5, '0, '0);

    // Row-bank select with consecutive reads.
    access(2'b11, 1'b1, 4'd3, '1, 32'h1111_1111);
    access(2'b11, 1'b1, 4'd11, '1, 32'h2222_2222);
    access(2'b11, 1'b0, 4'd3, '0, '0);
    access(2'b11, 1'b0, 4'd11, '0, '0);
    idle(1);

    // Last-read hold across idle cycles, a write, and a read of the other subbank.
    access(2'b11, 1'b0, 4'd3, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("latch_idle", bus.data_o, 32'h1111_1111);
    end
    access(2'b11, 1'b1, 4'd3, '1, 32'h3333_3333);
    check("latch_wr", bus.data_o, 32'h1111_1111);
    access(2'b10, 1'b0, 4'd11, '0, '0);
    idle(1);
    check("latch_mix", bus.data_o, 32'h2222_1111);

    // Random mixed traffic.
    for (int k = 0; k < 40; k++) begin
      access(NW'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             $urandom(), $urandom());
    end
    idle(2);

    // No-init instance: usable at once, outputs zero until its first read.
    check("ni_ready", W'(bus2.ready_o), W'(1));
    check("ni_pre_data", bus2.data_o, '0);
    bus2.v_i = 2'b11; bus2.w_i = 1'b1; bus2.addr_i = 4'd2; bus2.w_mask_i = '1; bus2.data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ni_wr_v", W'(bus2.data_v_o), '0);
    check("ni_wr_data", bus2.data_o, '0);
    bus2.w_i = 1'b0;
    @(negedge clk);
    bus2.v_i = '0;
    check("ni_rd_v", W'(bus2.data_v_o), W'(2'b11));
    check("ni_rd_data", bus2.data_o, 32'hDEAD_BEEF);
    @(negedge clk);
    check("ni_hold_v", W'(bus2.data_v_o), '0);
    check("ni_hold_data", bus2.data_o, 32'hDEAD_BEEF);

    // Reset from READY, then a second reset at init row 4 while writes are presented.
    reset_n = 1'b0;
    @(negedge clk);
    model_clear();
    check("rerst_ready", W'(bus.ready_o), '0);
    check("rerst_data", bus.data_o, '0);
    bus.v_i = 2'b11; bus.w_i = 1'b1; bus.addr_i = 4'd0; bus.w_mask_i = '1; bus.data_i = 32'hCAFE_F00D;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("reinit_cycles", 8);
    bus.v_i = '0;
    access(2'b11, 1'b0, 4'd0, '0, '0);
    access(2'b11, 1'b0, 4'd8, '0, '0);
    access(2'b11, 1'b0, 4'd5, '0, '0);
    access(2'b11, 1'b0, 4'd3, '0, '0);
    idle(3);
    check("drain", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
